ofm_writeback: RTL and testbench

OFM_WRITEBACK -- requirements
Module: ofm_writeback

---
 rtl/ofm_writeback.sv | 194 +++++++++++++++++++
 tb/tb_ofm_writeback.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_writeback.sv
// Purpose: queue requantised output-feature-map pixels and write one filter result per cycle to ofm memory.
// Latency: a push into an empty queue while idle produces the first memory write two cycles later.
// Backpressure: mem_ready=0 stalls writes with outputs held; pushes while full are dropped and flagged in overflow.

module ofm_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               wdat_i,
    output logic [W-1:0]               rdat_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    // A push is judged against the occupancy before any pop of the same cycle,
    // so a full queue never accepts a push even while it is being drained.
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdat_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Occupancy update for every push/pop combination.
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdat_i;
    end
endmodule

module ofm_writeback #(
    parameter int N      = 4,
    parameter int ACC_W  = 20,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 4,
    parameter int DEPTH  = 4,
    parameter int STRIDE = 169
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wrofm,
    input  logic [7:0]         ofmaddr,
    input  logic [N*ACC_W-1:0] psum,
    input  logic               last,
    input  logic               mem_ready,
    output logic               memWe,
    output logic [9:0]         memAddr,
    output logic [OUT_W-1:0]   memData,
    output logic               full,
    output logic               overflow,
    output logic               ready
);
    localparam int FW = (N > 1) ? $clog2(N) : 1;
    localparam logic signed [ACC_W-1:0] SAT = ACC_W'(2**OUT_W - 1);

    typedef struct packed {
        logic               last;
        logic [7:0]         addr;
        logic [N*ACC_W-1:0] psum;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [FW-1:0]  f_q, f_d;
    entry_t         hold_q, hold_d;
    logic           overflow_q, overflow_d;

    entry_t                  push_dat, head_dat;
    logic                    push_req, pop, empty;
    logic [$clog2(DEPTH):0]  count;
    logic signed [ACC_W-1:0] cur_sum, shifted;
    logic [9:0]              offset;

    // Pushes arriving after the final pixel has been written are ignored outright.
    assign push_req = wrofm && (state_q != S_DONE);
    assign pop      = (state_q == S_IDLE) && !empty;
    assign push_dat = '{last: last, addr: ofmaddr, psum: psum};

    ofm_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_req),
        .pop_i   (pop),
        .wdat_i  (push_dat),
        .rdat_o  (head_dat),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // Sticky drop flag: set whenever a live push meets a full queue.
    assign overflow_d = overflow_q | (push_req & full);
    assign overflow   = overflow_q;

    // Next-state logic: load a pixel in IDLE, step through its filters in WRITE.
    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    hold_d  = head_dat;
                    f_d     = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_ready) begin
                    if (f_q == FW'(N - 1)) begin
                        f_d     = '0;
                        state_d = hold_q.last ? S_DONE : S_IDLE;
                    end else begin
                        f_d = f_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, filter index, holding register and overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            f_q        <= '0;
            hold_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            f_q        <= f_d;
            hold_q     <= hold_d;
            overflow_q <= overflow_d;
        end
    end

    // Write outputs: address steps by one filter plane per index, data is the
    // clamped, shifted partial sum; everything reads zero when not writing.
    always_comb begin
        cur_sum = hold_q.psum[f_q*ACC_W +: ACC_W];
        shifted = cur_sum >>> SHIFT;
        offset  = 10'(f_q * STRIDE);
        memWe   = 1'b0;
        memAddr = '0;
        memData = '0;
        ready   = (state_q == S_DONE);
        if (state_q == S_WRITE) begin
            memWe   = 1'b1;
            memAddr = {2'b00, hold_q.addr} + offset;
            if (cur_sum <= 0)
                memData = '0;
            else if (shifted > SAT)
                memData = {OUT_W{1'b1}};
            else
                memData = shifted[OUT_W-1:0];
        end
    end
endmodule

// File: tb/tb_ofm_writeback.sv
// Purpose: scoreboard bench for ofm_writeback; a reference model queues every expected write.
// Latency: first write checked two edges after a push into an idle, empty block.
// Backpressure: mem_ready stalls, full/overflow drops and reset flushes are all exercised.

module tb_ofm_writeback;
    localparam int N = 4, ACC_W = 20, OUT_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               wrofm;
    logic [7:0]         ofmaddr;
    logic [N*ACC_W-1:0] psum;
    logic               last;
    logic               mem_ready;
    logic               memWe;
    logic [9:0]         memAddr;
    logic [OUT_W-1:0]   memData;
    logic               full, overflow, ready;

    int n_vec = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int last_wr_addr = 0;
    int exp_a[$];
    int exp_d[$];

    ofm_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .wrofm     (wrofm),
        .ofmaddr   (ofmaddr),
        .psum      (psum),
        .last      (last),
        .mem_ready (mem_ready),
        .memWe     (memWe),
        .memAddr   (memAddr),
        .memData   (memData),
        .full      (full),
        .overflow  (overflow),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Reference requantiser: negatives and zero clamp to 0, then divide by 2^4 and saturate.
    function automatic int qm(input int x);
        int y;
        if (x <= 0) return 0;
        y = x / 16;
        return (y > 255) ? 255 : y;
    endfunction

    function automatic int rnd();
        return int'($urandom_range(9000, 0)) - 1000;
    endfunction

    // Drive one push for one edge; when acc is set the model queues its four writes.
    task automatic push(input logic [7:0] a, input int p0, input int p1, input int p2,
                        input int p3, input logic lst, input bit acc);
        int p[4];
        p = '{p0, p1, p2, p3};
        wrofm   = 1'b1;
        ofmaddr = a;
        last    = lst;
        psum    = {20'(p3), 20'(p2), 20'(p1), 20'(p0)};
        if (acc) begin
            for (int f = 0; f < N; f++) begin
                exp_a.push_back((int'(a) + f * 169) % 1024);
                exp_d.push_back(qm(p[f]));
            end
        end
        @(posedge clk);
        #1;
        wrofm = 1'b0;
    endtask

    task automatic push_rnd(input bit acc);
        push(8'($urandom_range(255, 0)), rnd(), rnd(), rnd(), rnd(), 1'b0, acc);
    endtask

    task automatic do_reset(input logic wr_during);
        rst   = 1'b1;
        wrofm = wr_during;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wrofm = 1'b0;
        exp_a.delete();
        exp_d.delete();
    endtask

    // Wait for the model queue to empty (bounded), then idle a few cycles to catch stray writes.
    task automatic drain();
        for (int i = 0; i < 300 && exp_a.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_left", exp_a.size(), 0);
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Output monitor on the falling edge: every accepted write is matched against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (memWe && mem_ready) begin
                wr_cnt++;
                last_wr_addr = int'(memAddr);
                if (exp_a.size() == 0) begin
                    check("unexp_wr", memWe, 0);
                end else begin
                    check("wr_addr", memAddr, exp_a.pop_front());
                    check("wr_data", memData, exp_d.pop_front());
                end
            end else if (!memWe) begin
                check("idle_zero", {memAddr, memData}, 0);
            end
        end
    end

    initial begin
        int base;
        rst = 1'b1; wrofm = 1'b0; ofmaddr = '0; psum = '0; last = 1'b0; mem_ready = 1'b1;

        // Reset with a push request present: the push must be ignored.
        do_reset(1'b1);
        @(negedge clk);
        check("rst_we", memWe, 0);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_ready", ready, 0);
        repeat (3) @(posedge clk);
        #1;

        // Single pixel: f0=16, f1=300, f2=4095, f3=-3, base 5.
        push(8'd5, 16, 300, 4095, -3, 1'b0, 1'b1);
        @(negedge clk);
        check("lat_t1", memWe, 0);
        @(negedge clk);
        check("lat_t2", memWe, 1);
        check("first_addr", memAddr, 5);
        check("first_data", memData, 1);
        drain();

        // A pixel parks in WRITE stalled; 4 queued pushes fill the FIFO, the 5th drops.
        mem_ready = 1'b0;
        base = wr_cnt;
        push_rnd(1'b1);
        for (int i = 0; i < 5; i++) begin
            push_rnd(i < 4);
            check("burst_full", full, (i >= 3) ? 1 : 0);
            check("burst_ovf", overflow, (i == 4) ? 1 : 0);
        end
        mem_ready = 1'b1;
        drain();
        check("burst_wrs", wr_cnt - base, 4 + 16);
        check("ovf_sticky", overflow, 1);

        // Stall mid-pixel: mem_ready 1,0,0,1 with outputs held during the stall.
        do_reset(1'b0);
        check("ovf_cleared", overflow, 0);
        base = wr_cnt;
        push(8'd40, 1000, 2000, 3000, 50, 1'b0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("stall_addr0", memAddr, 40 + 169);
        check("stall_data0", memData, 125);
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_addr1", memAddr, 40 + 169);
        check("stall_data1", memData, 125);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        drain();
        check("stall_wrs", wr_cnt - base, 4);

        // Final pixel: writes end at 707, ready sticks, later pushes are ignored.
        push(8'd200, rnd(), rnd(), rnd(), rnd(), 1'b1, 1'b1);
        drain();
        check("last_addr", last_wr_addr, 707);
        check("done_ready", ready, 1);
        base = wr_cnt;
        push_rnd(1'b0);
        push_rnd(1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("done_nowr", wr_cnt - base, 0);
        check("done_ready2", ready, 1);
        check("done_ovf", overflow, 0);

        // Reset during the 2nd write of a pixel with 2 entries queued.
        do_reset(1'b0);
        push_rnd(1'b1);
        push_rnd(1'b1);
        push_rnd(1'b1);
        do_reset(1'b0);
        @(negedge clk);
        check("mid_rst_we", memWe, 0);
        check("mid_rst_full", full, 0);
        check("mid_rst_ready", ready, 0);
        base = wr_cnt;
        repeat (8) @(posedge clk);
        #1;
        check("flushed", wr_cnt - base, 0);
        push_rnd(1'b1);
        drain();
        check("post_rst_wrs", wr_cnt - base, 4);

        // Push and pop together at occupancy 2: occupancy holds, order preserved.
        mem_ready = 1'b0;
        push_rnd(1'b1);
        push_rnd(1'b1);
        push_rnd(1'b1);
        mem_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        push_rnd(1'b1);
        mem_ready = 1'b0;
        check("pp_full0", full, 0);
        push_rnd(1'b1);
        check("pp_full1", full, 0);
        push_rnd(1'b1);
        check("pp_full2", full, 1);
        mem_ready = 1'b1;
        drain();
        check("pp_ovf", overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute time guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
